// File: rtl/status_6502_pkg.sv
// Shared encodings for the 6502 status back end: flag-update classes,
// explicit set/clear opcodes and bit positions inside P.
package status_pkg_6502;

    typedef enum logic [2:0] {
        FOP_NONE  = 3'd0,
        FOP_NZ    = 3'd1,
        FOP_NZC   = 3'd2,
        FOP_NZCV  = 3'd3,
        FOP_BIT   = 3'd4,
        FOP_Z     = 3'd5,
        FOP_RSV6  = 3'd6,
        FOP_RSV7  = 3'd7
    } flag_op_e;

    typedef enum logic [2:0] {
        SC_NONE = 3'd0,
        SC_CLC  = 3'd1,
        SC_SEC  = 3'd2,
        SC_CLI  = 3'd3,
        SC_SEI  = 3'd4,
        SC_CLD  = 3'd5,
        SC_SED  = 3'd6,
        SC_CLV  = 3'd7
    } set_clr_e;

    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

    localparam logic [7:0] P_RESET = 8'h34;

endpackage

// File: rtl/status_6502_bcd_adjust.sv
// Decimal adjust of a binary ADC/SBC result. Each nibble is corrected
// independently; a nibble overflow is deliberately dropped, not carried.
module bcd_adjust_6502 (
    input  logic [7:0] alu_out,
    input  logic       hc,
    input  logic       co,
    input  logic       sub,
    output logic [7:0] adj_out
);

    logic [3:0] lo_corr;
    logic [3:0] hi_corr;

    always_comb begin
        if (sub) begin
            lo_corr = hc ? 4'h0 : 4'hA;
            hi_corr = co ? 4'h0 : 4'hA;
        end else begin
            lo_corr = hc ? 4'h6 : 4'h0;
            hi_corr = co ? 4'h6 : 4'h0;
        end
    end

    assign adj_out = {alu_out[7:4] + hi_corr, alu_out[3:0] + lo_corr};

endmodule

// File: rtl/status_6502.sv
// Result/status back end behind alu_6502: decimal-adjusts ADC/SBC results
// and owns the processor status register P.
import status_pkg_6502::*;

module status_6502 #(
    parameter bit CMOS_FLAGS = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RDY,
    input  logic [7:0] alu_out,
    input  logic       alu_co,
    input  logic       alu_hc,
    input  logic       alu_v,
    input  logic       adj_en,
    input  logic       adj_sub,
    input  logic [2:0] flag_op,
    input  logic [1:0] bit_data,
    input  logic [2:0] set_clr,
    input  logic       plp_load,
    input  logic [7:0] plp_data,
    input  logic       int_entry,
    input  logic       push_brk,
    output logic [7:0] res_out,
    output logic [7:0] P,
    output logic [7:0] p_push
);

    logic [7:0] adj_byte;
    logic [7:0] nz_src;
    logic [7:0] res_q, res_d;
    logic [7:0] p_q,   p_d;

    bcd_adjust_6502 u_bcd (
        .alu_out (alu_out),
        .hc      (alu_hc),
        .co      (alu_co),
        .sub     (adj_sub),
        .adj_out (adj_byte)
    );

    // 65C02 derives N/Z from the corrected byte; NMOS uses the raw binary result.
    assign nz_src = (CMOS_FLAGS && adj_en) ? adj_byte : alu_out;

    // Sources are applied lowest priority first so each higher source overrides
    // only the bits it actually writes.
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        res_d = adj_en ? adj_byte : alu_out;
        p_d   = p_q;

        case (set_clr_e'(set_clr))
            SC_CLC:  p_d[P_C] = 1'b0;
            SC_SEC:  p_d[P_C] = 1'b1;
            SC_CLI:  p_d[P_I] = 1'b0;
            SC_SEI:  p_d[P_I] = 1'b1;
            SC_CLD:  p_d[P_D] = 1'b0;
            SC_SED:  p_d[P_D] = 1'b1;
            SC_CLV:  p_d[P_V] = 1'b0;
            default: ;
        endcase

        case (flag_op_e'(flag_op))
            FOP_NZ: begin
                p_d[P_N] = nz_src[7];
                p_d[P_Z] = (nz_src == 8'h00);
            end
            FOP_NZC: begin
                p_d[P_N] = nz_src[7];
                p_d[P_Z] = (nz_src == 8'h00);
                p_d[P_C] = alu_co;
            end
            FOP_NZCV: begin
                p_d[P_N] = nz_src[7];
                p_d[P_Z] = (nz_src == 8'h00);
                p_d[P_C] = alu_co;
                p_d[P_V] = alu_v;
            end
            FOP_BIT: begin
                p_d[P_N] = bit_data[1];
                p_d[P_V] = bit_data[0];
                p_d[P_Z] = (nz_src == 8'h00);
            end
            FOP_Z:   p_d[P_Z] = (nz_src == 8'h00);
            default: ;
        endcase

        if (int_entry) begin
            p_d[P_I] = 1'b1;
            if (CMOS_FLAGS) p_d[P_D] = 1'b0;
        end

        if (plp_load) p_d = plp_data;

        p_d[P_U] = 1'b1;
        p_d[P_B] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= 8'h00;
            p_q   <= P_RESET;
        end else if (RDY) begin
            res_q <= res_d;
            p_q   <= p_d;
        end
    end

    assign res_out = res_q;
    assign P       = p_q;
    assign p_push  = {p_q[P_N], p_q[P_V], 1'b1, push_brk, p_q[P_D], p_q[P_I], p_q[P_Z], p_q[P_C]};

endmodule

// File: tb/tb_status_6502.sv
// Directed bench for status_6502: an NMOS and a CMOS instance share the same
// stimulus and are each compared against hand-computed P / result values.
module tb_status_6502;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       RDY;
    logic [7:0] alu_out;
    logic       alu_co, alu_hc, alu_v;
    logic       adj_en, adj_sub;
    logic [2:0] flag_op;
    logic [1:0] bit_data;
    logic [2:0] set_clr;
    logic       plp_load;
    logic [7:0] plp_data;
    logic       int_entry, push_brk;

    logic [7:0] res_n, p_n, push_n;
    logic [7:0] res_c, p_c, push_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    status_6502 #(.CMOS_FLAGS(1'b0)) dut_nmos (
        .clk(clk), .rst_n(rst_n), .RDY(RDY), .alu_out(alu_out), .alu_co(alu_co),
        .alu_hc(alu_hc), .alu_v(alu_v), .adj_en(adj_en), .adj_sub(adj_sub),
        .flag_op(flag_op), .bit_data(bit_data), .set_clr(set_clr), .plp_load(plp_load),
        .plp_data(plp_data), .int_entry(int_entry), .push_brk(push_brk),
        .res_out(res_n), .P(p_n), .p_push(push_n)
    );

    status_6502 #(.CMOS_FLAGS(1'b1)) dut_cmos (
        .clk(clk), .rst_n(rst_n), .RDY(RDY), .alu_out(alu_out), .alu_co(alu_co),
        .alu_hc(alu_hc), .alu_v(alu_v), .adj_en(adj_en), .adj_sub(adj_sub),
        .flag_op(flag_op), .bit_data(bit_data), .set_clr(set_clr), .plp_load(plp_load),
        .plp_data(plp_data), .int_entry(int_entry), .push_brk(push_brk),
        .res_out(res_c), .P(p_c), .p_push(push_c)
    );

    task automatic idle();
        RDY = 1'b1; alu_out = 8'h00; alu_co = 1'b0; alu_hc = 1'b0; alu_v = 1'b0;
        adj_en = 1'b0; adj_sub = 1'b0; flag_op = 3'd0; bit_data = 2'b00; set_clr = 3'd0;
        plp_load = 1'b0; plp_data = 8'h00; int_entry = 1'b0; push_brk = 1'b1;
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        alu_out = 8'h80; flag_op = 3'd3; alu_co = 1'b1; alu_v = 1'b1; set_clr = 3'd6;
        step();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checks++; if (p_n !== 8'h34) begin errors++; $display("FAIL reset_p_nmos got %h exp 34", p_n); end
        checks++; if (p_c !== 8'h34) begin errors++; $display("FAIL reset_p_cmos got %h exp 34", p_c); end
        checks++; if (res_n !== 8'h00) begin errors++; $display("FAIL reset_res got %h exp 00", res_n); end
        checks++; if (push_n !== 8'h34) begin errors++; $display("FAIL reset_push got %h exp 34", push_n); end
        step();
        checks++; if (p_n !== 8'h34) begin errors++; $display("FAIL reset_held_p got %h exp 34", p_n); end
        @(negedge clk);
        idle();
        rst_n = 1'b1;
        step();
        checks++; if (p_n !== 8'h34 || res_n !== 8'h00) begin
            errors++; $display("FAIL reset_release got p=%h res=%h exp p=34 res=00", p_n, res_n);
        end
    endtask

    task automatic test_adc_decimal();
        @(negedge clk);
        idle();
        alu_out = 8'hAF; alu_hc = 1'b1; alu_co = 1'b1; adj_en = 1'b1; flag_op = 3'd2;
        step();
        checks++; if (res_n !== 8'h05) begin errors++; $display("FAIL adc_res got %h exp 05", res_n); end
        checks++; if (p_n !== 8'hB5) begin errors++; $display("FAIL adc_p_nmos got %h exp B5", p_n); end
        checks++; if (p_c !== 8'h35) begin errors++; $display("FAIL adc_p_cmos got %h exp 35", p_c); end
    endtask

    task automatic test_sbc_decimal();
        @(negedge clk);
        idle();
        alu_out = 8'h2D; alu_hc = 1'b0; alu_co = 1'b1; adj_en = 1'b1; adj_sub = 1'b1; flag_op = 3'd2;
        step();
        checks++; if (res_c !== 8'h27) begin errors++; $display("FAIL sbc_res got %h exp 27", res_c); end
        checks++; if (p_n !== 8'h35) begin errors++; $display("FAIL sbc_p_nmos got %h exp 35", p_n); end
        checks++; if (p_c !== 8'h35) begin errors++; $display("FAIL sbc_p_cmos got %h exp 35", p_c); end
        @(negedge clk);
        alu_out = 8'h9A; adj_en = 1'b0; flag_op = 3'd0;
        step();
        checks++; if (res_n !== 8'h9A) begin errors++; $display("FAIL no_adj_res got %h exp 9A", res_n); end
    endtask

    task automatic test_bit();
        @(negedge clk);
        idle();
        alu_out = 8'h00; bit_data = 2'b11; flag_op = 3'd4;
        step();
        checks++; if (p_n !== 8'hF7) begin errors++; $display("FAIL bit_p_nmos got %h exp F7", p_n); end
        checks++; if (p_c !== 8'hF7) begin errors++; $display("FAIL bit_p_cmos got %h exp F7", p_c); end
    endtask

    task automatic test_plp_and_stall();
        @(negedge clk);
        idle();
        plp_load = 1'b1; plp_data = 8'hCF; flag_op = 3'd3; set_clr = 3'd4; alu_out = 8'h3C;
        step();
        checks++; if (p_n !== 8'hFF) begin errors++; $display("FAIL plp_p_nmos got %h exp FF", p_n); end
        checks++; if (p_c !== 8'hFF) begin errors++; $display("FAIL plp_p_cmos got %h exp FF", p_c); end
        checks++; if (res_n !== 8'h3C) begin errors++; $display("FAIL plp_res got %h exp 3C", res_n); end
        @(negedge clk);
        RDY = 1'b0; plp_data = 8'h00; alu_out = 8'h99; flag_op = 3'd2; set_clr = 3'd1; int_entry = 1'b1;
        step();
        step();
        checks++; if (p_n !== 8'hFF || p_c !== 8'hFF) begin
            errors++; $display("FAIL stall_p got %h/%h exp FF/FF", p_n, p_c);
        end
        checks++; if (res_n !== 8'h3C) begin errors++; $display("FAIL stall_res got %h exp 3C", res_n); end
    endtask

    task automatic test_int_entry();
        @(negedge clk);
        idle();
        int_entry = 1'b1; push_brk = 1'b0;
        #1;
        checks++; if (push_c !== 8'hEF) begin errors++; $display("FAIL irq_push got %h exp EF", push_c); end
        step();
        checks++; if (p_c !== 8'hF7) begin errors++; $display("FAIL irq_p_cmos got %h exp F7", p_c); end
        checks++; if (p_n !== 8'hFF) begin errors++; $display("FAIL irq_p_nmos got %h exp FF", p_n); end
    endtask

    task automatic test_set_clr();
        @(negedge clk);
        idle();
        set_clr = 3'd7;
        step();
        checks++; if (p_n !== 8'hBF || p_c !== 8'hB7) begin
            errors++; $display("FAIL clv got %h/%h exp BF/B7", p_n, p_c);
        end
        @(negedge clk);
        set_clr = 3'd2; flag_op = 3'd2; alu_out = 8'h80; alu_co = 1'b0;
        step();
        checks++; if (p_n !== 8'hBC || p_c !== 8'hB4) begin
            errors++; $display("FAIL sec_vs_nzc got %h/%h exp BC/B4", p_n, p_c);
        end
        @(negedge clk);
        set_clr = 3'd6; flag_op = 3'd5; alu_out = 8'h00; alu_co = 1'b1;
        step();
        checks++; if (p_n !== 8'hBE || p_c !== 8'hBE) begin
            errors++; $display("FAIL sed_zonly got %h/%h exp BE/BE", p_n, p_c);
        end
        @(negedge clk);
        set_clr = 3'd3; flag_op = 3'd6; alu_out = 8'h01; alu_co = 1'b1; alu_v = 1'b1;
        step();
        checks++; if (p_n !== 8'hBA || p_c !== 8'hBA) begin
            errors++; $display("FAIL cli_reserved got %h/%h exp BA/BA", p_n, p_c);
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        test_reset();
        test_adc_decimal();
        test_sbc_decimal();
        test_bit();
        test_plp_and_stall();
        test_int_entry();
        test_set_clr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
